// File: rtl/fpu_sequencer.sv
// Drives one typed operation through a selected stb/ack FP/conversion unit and returns a tagged 66-bit stack word.
// All outputs are registered; a unit that stalls for TIMEOUT busy cycles is abandoned with error 3.
module fpu_sequencer #(
  parameter int NUM_UNITS = 4,
  parameter int TIMEOUT   = 255,
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req,
  input  logic [UW:0]            i_unit,
  input  logic                   i_two_op,
  input  logic                   i_narrow,
  input  logic [1:0]             i_type_a,
  input  logic [1:0]             i_type_b,
  input  logic [1:0]             i_res_type,
  input  logic [65:0]            i_operand_a,
  input  logic [65:0]            i_operand_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [65:0]            o_result,
  output logic [1:0]             o_error,
  output logic [63:0]            o_u_a,
  output logic [63:0]            o_u_b,
  output logic [NUM_UNITS-1:0]   o_u_a_stb,
  output logic [NUM_UNITS-1:0]   o_u_b_stb,
  input  logic [NUM_UNITS-1:0]   i_u_a_ack,
  input  logic [NUM_UNITS-1:0]   i_u_b_ack,
  input  logic [64*NUM_UNITS-1:0] i_u_z,
  input  logic [NUM_UNITS-1:0]   i_u_z_stb,
  output logic [NUM_UNITS-1:0]   o_u_z_ack
);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TYPE = 2'd1;
  localparam logic [1:0] ERR_UNIT = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;
  localparam logic [NUM_UNITS-1:0] ONE = NUM_UNITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND_A, S_SEND_B, S_WAIT_Z} state_t;

  state_t               r_state, w_state;
  logic [UW-1:0]        r_unit, w_unit;
  logic                 r_two_op, w_two_op;
  logic                 r_narrow, w_narrow;
  logic [1:0]           r_res_type, w_res_type;
  logic [7:0]           r_cnt, w_cnt;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic [65:0]          r_result, w_result;
  logic [1:0]           r_error, w_error;
  logic [63:0]          r_u_a, w_u_a;
  logic [63:0]          r_u_b, w_u_b;
  logic [NUM_UNITS-1:0] r_a_stb, w_a_stb;
  logic [NUM_UNITS-1:0] r_b_stb, w_b_stb;
  logic [NUM_UNITS-1:0] r_z_ack, w_z_ack;

  logic [NUM_UNITS-1:0] w_sel;
  logic [63:0]          w_z;
  logic                 w_a_xfer, w_b_xfer, w_z_vld, w_tmo;

  // Only the latched unit's handshake lines are ever looked at.
  assign w_sel    = ONE << r_unit;
  assign w_z      = i_u_z[r_unit*64 +: 64];
  assign w_a_xfer = |(r_a_stb & i_u_a_ack & w_sel);
  assign w_b_xfer = |(r_b_stb & i_u_b_ack & w_sel);
  assign w_z_vld  = |(i_u_z_stb & w_sel);
  assign w_tmo    = (r_cnt == 8'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_unit     <= '0;
      r_two_op   <= 1'b0;
      r_narrow   <= 1'b0;
      r_res_type <= 2'd0;
      r_cnt      <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= 66'd0;
      r_error    <= ERR_NONE;
      r_u_a      <= 64'd0;
      r_u_b      <= 64'd0;
      r_a_stb    <= '0;
      r_b_stb    <= '0;
      r_z_ack    <= '0;
    end else begin
      r_state    <= w_state;
      r_unit     <= w_unit;
      r_two_op   <= w_two_op;
      r_narrow   <= w_narrow;
      r_res_type <= w_res_type;
      r_cnt      <= w_cnt;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_result   <= w_result;
      r_error    <= w_error;
      r_u_a      <= w_u_a;
      r_u_b      <= w_u_b;
      r_a_stb    <= w_a_stb;
      r_b_stb    <= w_b_stb;
      r_z_ack    <= w_z_ack;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_unit     = r_unit;
    w_two_op   = r_two_op;
    w_narrow   = r_narrow;
    w_res_type = r_res_type;
    w_cnt      = r_cnt;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_result   = r_result;
    w_error    = r_error;
    w_u_a      = r_u_a;
    w_u_b      = r_u_b;
    w_a_stb    = r_a_stb;
    w_b_stb    = r_b_stb;
    w_z_ack    = '0;

    if (r_state == S_IDLE) begin
      if (i_req) begin
        if (int'(i_unit) >= NUM_UNITS) begin
          w_done  = 1'b1;
          w_error = ERR_UNIT;
        end else if ((i_operand_a[65:64] != i_type_a) ||
                     (i_two_op && (i_operand_b[65:64] != i_type_b))) begin
          w_done  = 1'b1;
          w_error = ERR_TYPE;
        end else begin
          w_unit     = i_unit[UW-1:0];
          w_two_op   = i_two_op;
          w_narrow   = i_narrow;
          w_res_type = i_res_type;
          w_u_a      = i_operand_a[63:0];
          w_u_b      = i_operand_b[63:0];
          w_a_stb    = ONE << i_unit[UW-1:0];
          w_busy     = 1'b1;
          w_cnt      = 8'd0;
          w_state    = S_SEND_A;
        end
      end
    end else begin
      w_cnt = r_cnt + 8'd1;
      // A result arriving on the last budgeted cycle still wins over the abort.
      if ((r_state == S_WAIT_Z) && w_z_vld) begin
        w_result = {r_res_type, r_narrow ? {32'd0, w_z[31:0]} : w_z};
        w_z_ack  = w_sel;
        w_done   = 1'b1;
        w_error  = ERR_NONE;
        w_busy   = 1'b0;
        w_state  = S_IDLE;
      end else if (w_tmo) begin
        w_a_stb = '0;
        w_b_stb = '0;
        w_done  = 1'b1;
        w_error = ERR_TMO;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end else if ((r_state == S_SEND_A) && w_a_xfer) begin
        w_a_stb = '0;
        if (r_two_op) begin
          w_b_stb = w_sel;
          w_state = S_SEND_B;
        end else begin
          w_state = S_WAIT_Z;
        end
      end else if ((r_state == S_SEND_B) && w_b_xfer) begin
        w_b_stb = '0;
        w_state = S_WAIT_Z;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_result  = r_result;
  assign o_error   = r_error;
  assign o_u_a     = r_u_a;
  assign o_u_b     = r_u_b;
  assign o_u_a_stb = r_a_stb;
  assign o_u_b_stb = r_b_stb;
  assign o_u_z_ack = r_z_ack;

endmodule

// File: doc/fpu_sequencer.md
# fpu_sequencer

Multi-cycle floating-point/conversion unit sequencer for the WebAssembly CPU. It accepts one typed-operand operation at a time from the CPU EXEC stage and selects one of `NUM_UNITS` stb/ack-handshake units (double_to_float and the units that follow it). It drives the operand handshakes, collects and acknowledges the result, and returns a typed 66-bit stack word with a one-cycle `done` pulse. It also raises type, unit-select and timeout errors, so the CPU no longer hand-codes a handshake per opcode.

## Interface
- `NUM_UNITS`, 4: number of attached units; unit index width `UW = $clog2(NUM_UNITS)`, minimum 1.
- `TIMEOUT`, 255: busy-cycle budget before an abort; counter width 8 bits.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req`  in  1  start request; sampled only in IDLE.
- `unit`  in  UW+1  target unit index.
- `two_op`  in  1  1 = unit also takes operand B.
- `narrow`  in  1  1 = 32-bit result; result[63:32] forced to 0.
- `type_a`, `type_b`  in  2 each  required type tags of A and B.
- `res_type`  in  2  tag placed in result[65:64].
- `operand_a`, `operand_b`  in  66 each  stack words {type, value}.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  66  {res_type, value}; valid while `done`=1, held until the next accept.
- `error`  out  2  0 = none, 1 = type mismatch, 2 = bad unit, 3 = timeout; valid with `done`.
- `u_a`, `u_b`  out  64 each  shared operand buses to all units.
- `u_a_stb`, `u_b_stb`  out  NUM_UNITS each  one-hot operand strobes.
- `u_a_ack`, `u_b_ack`  in  NUM_UNITS each  unit operand acks.
- `u_z`  in  64*NUM_UNITS  unit results; unit i occupies bits [64i+63:64i].
- `u_z_stb`  in  NUM_UNITS  result valid.
- `u_z_ack`  out  NUM_UNITS  one-hot result acknowledge.

## Operation
- States: IDLE, SEND_A, SEND_B, WAIT_Z.
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - `busy`, `done`, all `*_stb` and `u_z_ack` = 0.
  - `error` = 0.
  - `result` = 0.
  - timeout counter = 0.
- IDLE, on `req`:
  - If `unit >= NUM_UNITS`: `done`=1, `error`=2; stay IDLE.
  - Else if `operand_a[65:64] != type_a`, or `two_op` and `operand_b[65:64] != type_b`: `done`=1, `error`=1; stay IDLE.
  - The unit check has priority over the type check.
  - Otherwise: latch the unit index, `narrow` and `res_type`; drive `u_a` = operand_a[63:0] and `u_b` = operand_b[63:0]; set `u_a_stb[unit]`=1, `busy`=1, counter = 0; go to SEND_A.
- SEND_A: hold the strobe until a posedge samples `u_a_stb & u_a_ack` for the selected unit. Then clear `u_a_stb`. If `two_op`, set `u_b_stb` and go to SEND_B; otherwise go to WAIT_Z.
- SEND_B: same handshake on B, then go to WAIT_Z.
- WAIT_Z: on a posedge with `u_z_stb[unit]`=1:
  - `result` = {res_type, narrow ? {32'b0, z[31:0]} : z}.
  - `u_z_ack[unit]`=1, `done`=1, `error`=0, `busy`=0; go to IDLE.
- `u_z_ack` and `done` are high for exactly one cycle.
- Acks and strobes on non-selected units are ignored.
- Timeout:
  - The counter increments on every posedge in SEND_A, SEND_B or WAIT_Z.
  - If the counter equals `TIMEOUT` at a posedge and the state is not completing: clear all strobes, `done`=1, `error`=3, `busy`=0, go to IDLE.
  - The aborted unit is not acknowledged; the CPU traps on `error`=3.
- `req` outside IDLE is ignored; no queuing.
- A `req` in the cycle where `u_z_ack` is high is accepted normally.
- `reset` mid-operation: all outputs return to reset values on the next posedge. Attached units share `reset`.

## Timing
- Accept latency: `req` sampled at posedge N → `busy` and `u_a_stb` high from cycle N+1.
- Error latency: `req` with error at posedge N → `done` and `error` high in cycle N+1; `busy` never rises.
- Minimum single-operand latency: 3 cycles from `req` to `done`.
  - Ack already high: transfer at posedge N+1.
  - WAIT_Z from cycle N+2; `z_stb` sampled at posedge N+2.
  - `done` in cycle N+3.
- Each operand handshake completes in the cycle where strobe and ack are both high at a posedge; the strobe is low the following cycle.
- Timeout abort: `done` in cycle N+2+TIMEOUT after accept at N.

## Test plan
- Unit 0 (d2f model), `two_op`=0, `narrow`=1, A = {f64, 0x3FF0000000000000}, `type_a`=f64, z = 0x3F800000 → `done` at the 3rd cycle, `result` = {f32, 0x000000003F800000}, `error`=0, one-cycle `u_z_ack[0]`.
- Unit 1, `two_op`=1, ack delays of 2 cycles on A and 3 on B, z returned 5 cycles later → strobes hold until ack; exactly one A transfer and one B transfer; `done` once with the 64-bit z.
- `type_a` = f64 with A tagged i32 → `done` next cycle, `error`=1; no strobe ever rises.
- `unit`=4 with `NUM_UNITS`=4 → `error`=2; an unknown unit together with a type mismatch also reports `error`=2.
- Unit never raises `z_stb`, `TIMEOUT`=10 → `done` with `error`=3 at accept+12; all strobes are 0 afterwards; a new `req` in the next cycle is accepted.
- `reset` asserted during SEND_B → every output is 0 the next cycle; `req` while busy is ignored; `req` during the `u_z_ack` cycle is accepted.
